// File: rtl/fb_arbiter_if.sv
// rtl/fb_arbiter_if.sv - frame buffer arbiter bus bundle (display read, PPU write, frame RAM port)
//
// Purpose: groups the handshake and bus signals of the frame buffer arbiter.
//   master : the surrounding system (display timing, PPU, frame RAM, control).
//   slave  : the arbiter itself.
// Signals:
//   vga_clk    pixel enable; high requests a read slot this cycle
//   vga_addr   display read address
//   vga_data   registered read data back to the display
//   ppu_wr     PPU pixel write strobe
//   ppu_addr   PPU write address
//   ppu_data   PPU pixel value
//   ppu_ready  write FIFO not full
//   ram_addr   frame RAM address
//   ram_wdata  frame RAM write data
//   ram_we     frame RAM write enable
//   ram_rdata  frame RAM read data, one cycle after the address
//   ovf        sticky overflow flag
//   clr_ovf    synchronous clear of ovf
interface fb_arbiter_if;
  logic        vga_clk;
  logic [15:0] vga_addr;
  logic [7:0]  vga_data;
  logic        ppu_wr;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_data;
  logic        ppu_ready;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic        ovf;
  logic        clr_ovf;

  modport master (
    output vga_clk, vga_addr, ppu_wr, ppu_addr, ppu_data, ram_rdata, clr_ovf,
    input  vga_data, ppu_ready, ram_addr, ram_wdata, ram_we, ovf
  );

  modport slave (
    input  vga_clk, vga_addr, ppu_wr, ppu_addr, ppu_data, ram_rdata, clr_ovf,
    output vga_data, ppu_ready, ram_addr, ram_wdata, ram_we, ovf
  );
endinterface

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port frame RAM arbiter between display reads and queued PPU writes
//
// Purpose: each cycle grants the frame RAM port to one slot (READ, WRITE or IDLE).
//   Display reads win over queued writes, except that a write is forced after
//   STARVE_MAX consecutive read slots lost by a non-empty write FIFO.
// Ports:
//   sysclk  sole clock, rising edge
//   reset   asynchronous active-low reset
//   bus     fb_arbiter_if.slave (display, PPU and frame RAM signals)
module fb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic          sysclk,
  input logic          reset,
  fb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [ST_W-1:0]  ST_MAX_C = ST_W'(STARVE_MAX);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_WRITE} slot_e;

  logic [23:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ST_W-1:0]  starve_q, starve_d;
  logic             rd_pend_q, rd_pend_d;
  logic [7:0]       vga_data_q, vga_data_d;
  logic             ovf_q, ovf_d;

  slot_e       slot;
  logic [23:0] head;
  logic        fifo_empty, ppu_ready, forced, push, pop;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  // Registered count only: a pop in the same cycle does not open a slot.
  assign ppu_ready  = (count_q < DEPTH_C);
  assign forced     = (starve_q == ST_MAX_C) && !fifo_empty;
  assign push       = bus.ppu_wr && ppu_ready;
  assign pop        = (slot == SLOT_WRITE);

  always_comb begin
    slot = SLOT_IDLE;
    if (forced)              slot = SLOT_WRITE;
    else if (bus.vga_clk)    slot = SLOT_READ;
    else if (!fifo_empty)    slot = SLOT_WRITE;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    rd_pend_d  = (slot == SLOT_READ);
    vga_data_d = vga_data_q;
    ovf_d      = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Only read slots taken while writes are waiting count as lost opportunities.
    if (fifo_empty || pop)
      starve_d = '0;
    else if ((slot == SLOT_READ) && (starve_q != ST_MAX_C))
      starve_d = starve_q + 1'b1;

    if (rd_pend_q) vga_data_d = bus.ram_rdata;

    // A dropped write sets the flag even when a clear arrives in the same cycle.
    if (bus.ppu_wr && !ppu_ready) ovf_d = 1'b1;
    else if (bus.clr_ovf)         ovf_d = 1'b0;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rd_pend_q  <= 1'b0;
      vga_data_q <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      vga_data_q <= vga_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.ppu_addr, bus.ppu_data};
  end

  assign bus.ram_we    = (slot == SLOT_WRITE);
  assign bus.ram_addr  = (slot == SLOT_WRITE) ? head[23:8] : bus.vga_addr;
  assign bus.ram_wdata = fifo_empty ? 8'h00 : head[7:0];
  assign bus.vga_data  = vga_data_q;
  assign bus.ppu_ready = ppu_ready;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - self-checking bench for fb_arbiter
module tb_fb_arbiter;

  logic sysclk = 1'b0;
  logic reset;
  always #5 sysclk = ~sysclk;

  fb_arbiter_if bus();

  fb_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  logic [7:0]  env_ram [65536];
  logic [7:0]  mdl_ram [65536];
  logic [23:0] mq [$];
  int          m_starve = 0;
  bit          m_ovf = 0;
  bit          m_pend = 0;
  logic [7:0]  m_pend_val = 8'h00;
  logic [7:0]  m_vga = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame RAM: synchronous write, read data one cycle after the address.
  always @(posedge sysclk) begin
    if (bus.ram_we) env_ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= env_ram[bus.ram_addr];
  end

  // Queue-level model and per-cycle compare.
  always @(negedge sysclk) begin
    int          cnt;
    bit          rd, wr;
    logic [23:0] hd;
    if (!reset) begin
      chk("rst_ready", bus.ppu_ready, 1);
      chk("rst_we", bus.ram_we, 0);
      chk("rst_addr", bus.ram_addr, bus.vga_addr);
      chk("rst_vga", bus.vga_data, 0);
      chk("rst_ovf", bus.ovf, 0);
      mq.delete();
      m_starve = 0;
      m_ovf    = 0;
      m_pend   = 0;
      m_vga    = 8'h00;
    end else begin
      cnt = mq.size();
      hd  = (cnt > 0) ? mq[0] : 24'h0;
      wr  = (cnt > 0) && ((m_starve == 8) || !bus.vga_clk);
      rd  = !wr && bus.vga_clk;

      chk("ready", bus.ppu_ready, cnt < 4);
      chk("we", bus.ram_we, wr);
      if (wr) begin
        chk("waddr", bus.ram_addr, hd[23:8]);
        chk("wdata", bus.ram_wdata, hd[7:0]);
      end else begin
        chk("raddr", bus.ram_addr, bus.vga_addr);
      end
      chk("ovf", bus.ovf, m_ovf);
      chk("vga_data", bus.vga_data, m_vga);
      if (bus.ram_we) we_cnt++;

      if (m_pend) m_vga = m_pend_val;
      m_pend = rd;
      if (rd) m_pend_val = mdl_ram[bus.vga_addr];
      if (wr) begin
        mdl_ram[hd[23:8]] = hd[7:0];
        void'(mq.pop_front());
      end
      if (bus.ppu_wr && cnt < 4) mq.push_back({bus.ppu_addr, bus.ppu_data});
      if (bus.ppu_wr && cnt >= 4) m_ovf = 1;
      else if (bus.clr_ovf)       m_ovf = 0;
      if (cnt == 0 || wr)             m_starve = 0;
      else if (rd && m_starve < 8)    m_starve = m_starve + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    bus.ppu_wr   = 1'b1;
    bus.ppu_addr = a;
    bus.ppu_data = d;
    step(1);
    bus.ppu_wr   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      env_ram[i] = 8'h00;
      mdl_ram[i] = 8'h00;
    end
    env_ram[16'h0010] = 8'h21;
    mdl_ram[16'h0010] = 8'h21;

    reset        = 1'b0;
    bus.vga_clk  = 1'b0;
    bus.vga_addr = 16'h0000;
    bus.ppu_wr   = 1'b0;
    bus.ppu_addr = 16'h0000;
    bus.ppu_data = 8'h00;
    bus.clr_ovf  = 1'b0;
    bus.ram_rdata = 8'h00;
    step(3);
    reset = 1'b1;
    step(2);

    // Reads only, empty FIFO.
    bus.vga_addr = 16'h0010;
    we_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.vga_clk = (i % 2 == 0);
      step(1);
    end
    bus.vga_clk = 1'b0;
    chk("r034_vga", bus.vga_data, 8'h21);
    chk("r034_nowe", we_cnt, 0);

    // Four back-to-back writes, no reads.
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.ppu_wr   = 1'b1;
      bus.ppu_addr = 16'h0100 + 16'(i);
      bus.ppu_data = 8'(i + 1);
      step(1);
    end
    bus.ppu_wr = 1'b0;
    step(4);
    for (int i = 0; i < 4; i++) chk("r035_ram", env_ram[16'h0100 + 16'(i)], i + 1);
    chk("r035_wecnt", we_cnt, 4);
    chk("r035_ovf", bus.ovf, 0);

    // Constant reads: overflow on 5th push, forced write every 9 cycles.
    bus.vga_clk  = 1'b1;
    bus.vga_addr = 16'h0100;
    we_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bus.ppu_wr   = 1'b1;
      bus.ppu_addr = 16'h0300 + 16'(i);
      bus.ppu_data = 8'h30 + 8'(i);
      if (i == 4) chk("r036_ready0", bus.ppu_ready, 0);
      step(1);
    end
    bus.ppu_wr = 1'b0;
    chk("r036_ovf", bus.ovf, 1);
    step(31);
    chk("r036_wecnt", we_cnt, 3);
    chk("r036_vga", bus.vga_data, 8'h01);
    bus.vga_clk = 1'b0;
    step(3);
    chk("r036_last", env_ram[16'h0303], 8'h33);
    chk("r036_drop", env_ram[16'h0304], 8'h00);

    // Full FIFO, push during pop is dropped; clear of ovf.
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    chk("r037_clr0", bus.ovf, 0);
    bus.vga_clk = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h0400 + 16'(i), 8'h40 + 8'(i));
    bus.vga_clk = 1'b0;
    push(16'h0404, 8'h44);
    bus.vga_clk = 1'b1;
    chk("r037_ready", bus.ppu_ready, 1);
    chk("r037_ovf", bus.ovf, 1);
    push(16'h0405, 8'h45);
    chk("r037_full", bus.ppu_ready, 0);
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    chk("r037_clr", bus.ovf, 0);
    bus.vga_clk = 1'b0;
    step(5);
    chk("r037_drop", env_ram[16'h0404], 8'h00);
    chk("r037_kept", env_ram[16'h0405], 8'h45);

    // Reset mid-operation with queued writes and a pending read.
    bus.vga_clk  = 1'b1;
    bus.vga_addr = 16'h0400;
    for (int i = 0; i < 3; i++) push(16'h0500 + 16'(i), 8'h50 + 8'(i));
    chk("r038_pre", bus.vga_data, 8'h40);
    reset = 1'b0;
    #1;
    chk("r038_vga", bus.vga_data, 0);
    chk("r038_ready", bus.ppu_ready, 1);
    bus.vga_clk = 1'b0;
    step(2);
    reset = 1'b1;
    we_cnt = 0;
    step(6);
    chk("r038_nowe", we_cnt, 0);
    chk("r038_ram", env_ram[16'h0500], 8'h00);

    // Ten writes through the FIFO with pointer wrap.
    bus.vga_addr = 16'h0010;
    we_cnt = 0;
    bus.vga_clk = 1'b1;
    push(16'h0600, 8'h60);
    push(16'h0601, 8'h61);
    bus.vga_clk = 1'b0;
    for (int i = 2; i < 10; i++) push(16'h0600 + 16'(i), 8'h60 + 8'(i));
    step(4);
    for (int i = 0; i < 10; i++) chk("r039_ram", env_ram[16'h0600 + 16'(i)], 8'h60 + 8'(i));
    chk("r039_wecnt", we_cnt, 10);
    chk("r039_ovf", bus.ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
